// File: rtl/x7seg_pkg.sv
// Shared constants for the x7seg display driver and monitor.
// Segment patterns are active-low, bit 6 = a ... bit 0 = g.
package x7seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/x7seg_monitor_seg_decode.sv
// Combinational segment-pattern to hex-nibble decoder.
// Any pattern outside the sixteen legal encodings reports legal = 0.
module seg_decode
    import x7seg_pkg::*;
(
    input  logic [6:0] a_to_g,
    output logic [3:0] nib,
    output logic       legal
);

    // Reverse lookup of the shared pattern table.
    always_comb begin
        nib   = 4'h0;
        legal = 1'b1;
        case (a_to_g)
            SEG_0:   nib = 4'h0;
            SEG_1:   nib = 4'h1;
            SEG_2:   nib = 4'h2;
            SEG_3:   nib = 4'h3;
            SEG_4:   nib = 4'h4;
            SEG_5:   nib = 4'h5;
            SEG_6:   nib = 4'h6;
            SEG_7:   nib = 4'h7;
            SEG_8:   nib = 4'h8;
            SEG_9:   nib = 4'h9;
            SEG_A:   nib = 4'hA;
            SEG_B:   nib = 4'hB;
            SEG_C:   nib = 4'hC;
            SEG_D:   nib = 4'hD;
            SEG_E:   nib = 4'hE;
            SEG_F:   nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/x7seg_monitor.sv
// Seven-segment receive monitor: samples the multiplexed display lines,
// accepts a digit once it has been stable for STABLE_CYCLES edges, and
// publishes the 16-bit value when all four digit positions have been seen.
module x7seg_monitor
    import x7seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [6:0]  a_to_g,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  seen,
    output logic        err,
    output logic        err_sticky
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [10:0] smp;
    logic [7:0]  cnt;
    logic [15:0] digit_buf;

    logic [10:0] sample;
    logic        same;
    logic        accept;
    logic [3:0]  dec_nib;
    logic        dec_legal;
    logic        blank;
    logic        single;
    logic [1:0]  idx;
    logic        wr_en;
    logic        bad;
    logic [15:0] buf_nx;
    logic [3:0]  seen_nx;

    assign sample = {an, a_to_g};
    assign same   = (sample == smp);
    // The accept fires exactly once, on the edge the counter reaches STABLE.
    assign accept = same && (cnt == STABLE - 8'd1);

    // Classification uses the registered sample, which equals the input on an accept edge.
    seg_decode u_seg_decode (
        .a_to_g (smp[6:0]),
        .nib    (dec_nib),
        .legal  (dec_legal)
    );

    // Map the digit enables to a position; multiple enables are neither blank nor single.
    always_comb begin
        blank  = 1'b0;
        single = 1'b1;
        idx    = 2'd0;
        case (smp[10:7])
            4'b1111: begin
                blank  = 1'b1;
                single = 1'b0;
            end
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: single = 1'b0;
        endcase
    end

    // Next buffer and seen mask, including the nibble written on this edge.
    always_comb begin
        wr_en   = accept && single && dec_legal;
        bad     = accept && !blank && !(single && dec_legal);
        buf_nx  = digit_buf;
        seen_nx = seen;
        if (wr_en) begin
            buf_nx[{idx, 2'b00} +: 4] = dec_nib;
            seen_nx = seen | (4'b0001 << idx);
        end
    end

    // Sampler and saturating stability counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            smp <= '0;
            cnt <= '0;
        end else begin
            smp <= sample;
            if (!same)
                cnt <= 8'd1;
            else if (cnt != STABLE)
                cnt <= cnt + 8'd1;
        end
    end

    // Digit buffer, frame completion and error reporting.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            digit_buf   <= '0;
            value       <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            digit_buf   <= buf_nx;
            frame_valid <= 1'b0;
            err         <= bad;
            err_sticky  <= err_sticky | bad;
            if (wr_en && (seen_nx == 4'hF)) begin
                value       <= buf_nx;
                frame_valid <= 1'b1;
                seen        <= '0;
            end else begin
                seen <= seen_nx;
            end
        end
    end

endmodule

// File: tb/tb_x7seg_monitor.sv
// Directed bench for x7seg_monitor with a frame scoreboard.
module tb_x7seg_monitor;

    logic        clk = 1'b0;
    logic        clr;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  seen;
    logic        err;
    logic        err_sticky;

    int checks   = 0;
    int failures = 0;
    int fv_count = 0;
    int err_count = 0;
    logic [15:0] exp_q[$];

    // Patterns written out independently of the design package.
    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PA = 7'b0001000;
    localparam logic [6:0] PC = 7'b0110001;
    localparam logic [6:0] PE = 7'b0110000;
    localparam logic [6:0] PX = 7'b1111110;
    localparam logic [6:0] OFF = 7'b1111111;

    x7seg_monitor #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .a_to_g      (a_to_g),
        .an          (an),
        .value       (value),
        .frame_valid (frame_valid),
        .seen        (seen),
        .err         (err),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern and hold it for n rising edges; returns just after a falling edge.
    task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
        an     = a;
        a_to_g = s;
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Scoreboard: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (err === 1'b1) err_count++;
        if (frame_valid === 1'b1) begin
            fv_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL frame_unexpected observed=%0h expected=none", value);
            end else begin
                check("frame_value", {16'h0, value}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        int ec;

        // Reset with arbitrary inputs present.
        clr    = 1'b1;
        an     = 4'b1110;
        a_to_g = PA;
        repeat (3) @(negedge clk);
        #1;
        check("rst_value", {16'h0, value}, 32'h0);
        check("rst_flags", {27'h0, frame_valid, seen, err, err_sticky}, 32'h0);
        clr = 1'b0;
        step(4'b1111, OFF, 2);
        check("post_rst_value", {16'h0, value}, 32'h0);
        check("post_rst_flags", {27'h0, frame_valid, seen, err, err_sticky}, 32'h0);

        // Clean frame: 00AA.
        step(4'b1110, PA, 4);
        check("clean_seen0", {28'h0, seen}, 32'h1);
        step(4'b1101, PA, 4);
        check("clean_seen1", {28'h0, seen}, 32'h3);
        step(4'b1011, P0, 4);
        check("clean_seen2", {28'h0, seen}, 32'h7);
        check("clean_no_fv_yet", {31'h0, frame_valid}, 32'h0);
        fc = fv_count;
        exp_q.push_back(16'h00AA);
        step(4'b0111, P0, 4);
        check("clean_fv", {31'h0, frame_valid}, 32'h1);
        check("clean_value", {16'h0, value}, 32'h00AA);
        check("clean_seen_clr", {28'h0, seen}, 32'h0);
        step(4'b1111, OFF, 4);
        check("clean_single_pulse", fv_count, fc + 1);
        check("clean_fv_low", {31'h0, frame_valid}, 32'h0);

        // Glitch shorter than the stability window.
        ec = err_count;
        step(4'b1110, P1, 3);
        step(4'b1111, OFF, 4);
        check("glitch_seen", {28'h0, seen}, 32'h0);
        check("glitch_err", err_count, ec);
        check("glitch_sticky", {31'h0, err_sticky}, 32'h0);

        // Illegal segments held longer than the window: one error.
        step(4'b1110, PX, 6);
        check("illegal_err", err_count, ec + 1);
        check("illegal_sticky", {31'h0, err_sticky}, 32'h1);
        check("illegal_seen", {28'h0, seen}, 32'h0);
        step(4'b1111, OFF, 4);

        // Multi-enable with a digit already captured.
        step(4'b1110, P2, 4);
        check("multi_pre_seen", {28'h0, seen}, 32'h1);
        step(4'b1100, P8, 4);
        check("multi_err", err_count, ec + 2);
        check("multi_seen", {28'h0, seen}, 32'h1);

        // Reset mid-frame.
        step(4'b1110, P3, 4);
        step(4'b1101, P5, 4);
        check("mid_seen", {28'h0, seen}, 32'h3);
        clr = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_value", {16'h0, value}, 32'h0);
        check("mid_rst_flags", {27'h0, frame_valid, seen, err, err_sticky}, 32'h0);
        clr = 1'b0;
        fc = fv_count;
        step(4'b1011, P7, 4);
        step(4'b0111, PC, 4);
        check("after_rst_seen", {28'h0, seen}, 32'hC);
        step(4'b1110, P1, 4);
        check("after_rst_seen3", {28'h0, seen}, 32'hD);
        check("after_rst_no_fv", fv_count, fc);
        // Overwrite digit 0 before completing the frame.
        step(4'b1110, PE, 4);
        check("recapture_seen", {28'h0, seen}, 32'hD);
        exp_q.push_back(16'hC79E);
        step(4'b1101, P9, 4);
        check("final_fv", {31'h0, frame_valid}, 32'h1);
        check("final_value", {16'h0, value}, 32'hC79E);
        check("final_seen", {28'h0, seen}, 32'h0);
        check("final_fv_count", fv_count, fc + 1);
        step(4'b1111, OFF, 4);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/x7seg_monitor.md
# x7seg_monitor

Receive-side counterpart of the x7seg display driver. It watches the multiplexed seven-segment lines (`a_to_g`, `an`) and decodes each lit digit back into a hex nibble. Once all four digit positions have been captured, it presents the reconstructed 16-bit value with a one-cycle strobe. It sits beside the driver in benches and loopback builds so the displayed value can be checked in hardware rather than by eye.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a digit is accepted (range 2..255).
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `clr` input, 1 bit: reset, asynchronous, active-high.
- `a_to_g` input, 7 bits: segment lines, active-low; bit 6 = a, bit 0 = g.
- `an` input, 4 bits: digit enables, active-low; bit 0 = rightmost digit (nibble 0).
- `value` output, 16 bits: last completed frame, nibble i taken from digit i.
- `frame_valid` output, 1 bit: one-cycle pulse when `value` updates.
- `seen` output, 4 bits: digits captured in the current frame.
- `err` output, 1 bit: one-cycle pulse on a rejected stable sample.
- `err_sticky` output, 1 bit: set by `err`, cleared only by `clr`.

## Operation
- Input register `smp` holds `{an, a_to_g}` from every edge.
- Counter `cnt` (8 bits):
  - If the incoming `{an, a_to_g}` differs from `smp`, `cnt` loads 1.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES`.
- Accept event: the edge where `cnt` goes from `STABLE_CYCLES-1` to `STABLE_CYCLES`.
  - Exactly one accept per stable run; holding the same pattern longer produces no further accepts.
- On accept, classify the sample:
  - `an` = 4'b1111 (blanked): ignored, no error.
  - `an` with exactly one zero: decode `a_to_g`.
    - Legal pattern: write the nibble into `buf[idx]` and set `seen[idx]`.
    - Illegal pattern: `err` pulses; `buf` and `seen` are unchanged.
  - `an` with two or more zeros: `err` pulses; `buf` and `seen` are unchanged.
- Legal patterns (a..g, active-low) are the only valid encodings:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Re-capturing a digit already in `seen` overwrites `buf[idx]`; `seen` stays set.
- Frame completion, on the accept edge where `seen` becomes 4'b1111:
  - `value` loads the assembled `buf`, including the nibble written on that same edge.
  - `frame_valid` is 1 for that cycle.
  - `seen` clears to 0.
- Reset: `smp`=0, `cnt`=0, `buf`=0, `value`=0, `seen`=0, `frame_valid`=0, `err`=0, `err_sticky`=0.
  - Asserting `clr` mid-frame discards the partial frame; the next frame needs all four digits again.

## Timing
- An input pattern first present before edge k, and held, is accepted on edge k+STABLE_CYCLES-1.
  - `seen`, `frame_valid` and `err` are visible after that edge.
- A pattern held fewer than `STABLE_CYCLES` edges is never accepted, which rejects scan-transition glitches.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Same-edge events:
  - Accept with frame completion: `frame_valid` and the `seen` clear occur together.
  - An `err` accept never completes a frame.
- `clr` overrides every other event asynchronously.

## Structure
- Package `x7seg_pkg`:
  - The sixteen segment-pattern constants, shared with the x7seg driver.
  - Constant `NUM_DIGITS` = 4.
- Sub-module `seg_decode`: combinational, `a_to_g[6:0]` → `nib[3:0]` plus `legal`; one instance.
- The top level holds the sampler, stability counter, digit buffer and frame logic.

## Test plan
- Reset: hold `clr`=1 with arbitrary inputs, then release. Required: all outputs 0 both during and after `clr` until the first accept.
- Clean frame, `STABLE_CYCLES`=4, each step held 4 cycles:
  - Drive an=1110 with 0001000, then an=1101 with 0001000, then an=1011 with 0000001, then an=0111 with 0000001.
  - Required: `value`=16'h00AA with a single `frame_valid` pulse on the fourth accept edge, and `seen`=0 afterwards.
- Glitch rejection: an=1110 with 1001111 held 3 cycles, then an=1111. Required: `seen` stays 0 and `err` stays 0.
- Illegal segments: an=1110 with 1111110 held 6 cycles. Required: `err` pulses exactly once, `err_sticky`=1, `seen`=0.
- Multi-enable: an=1100 with 0000000 held 4 cycles. Required: one `err` pulse and `seen` unchanged.
- Reset mid-frame:
  - Capture digits 0 and 1, then pulse `clr`, then capture digits 2 and 3. Required: no `frame_valid`.
  - Then capture digits 0 and 1 again. Required: `frame_valid` fires, and `value` matches the last patterns driven.
